// File: rtl/fccc_lock_reset_seq.sv
// Fabric clock-ready / reset sequencer on the CCC GL0 clock.
// Qualifies a synchronized LOCK, stretches reset, and tracks lock losses seen in RUN.
module fccc_lock_reset_seq #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16,
  parameter int CNT_W              = 16,
  parameter int LOSS_CNT_W         = 8
) (
  input  logic                  GL0,
  input  logic                  RESET,
  input  logic                  LOCK,
  input  logic                  EXT_RST_REQ,
  input  logic                  LOSS_CLR,
  output logic                  FABRIC_RESET_N,
  output logic                  CLK_READY,
  output logic [LOSS_CNT_W-1:0] LOCK_LOSS_CNT,
  output logic                  LOCK_LOST,
  output logic [1:0]            STATE
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'b00,
    STABLE    = 2'b01,
    HOLD      = 2'b10,
    RUN       = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [LOSS_CNT_W-1:0] LOSS_MAX = {LOSS_CNT_W{1'b1}};

  state_t                  state_r;
  state_t                  next_state_s;
  logic [SYNC_STAGES-1:0]  sync_r;
  logic                    lock_s;
  logic [CNT_W-1:0]        cnt_r;
  logic [CNT_W-1:0]        cnt_next_s;
  logic                    loss_s;
  logic                    run_next_s;
  logic [LOSS_CNT_W-1:0]   loss_base_s;
  logic [LOSS_CNT_W-1:0]   loss_cnt_next_s;
  logic                    lost_next_s;
  logic                    fabric_reset_n_r;
  logic                    clk_ready_r;
  logic [LOSS_CNT_W-1:0]   loss_cnt_r;
  logic                    lost_r;

  // LOCK synchronizer chain; LOCK is asynchronous to GL0.
  always_ff @(posedge GL0 or posedge RESET) begin
    if (RESET) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], LOCK};
    end
  end

  assign lock_s = sync_r[SYNC_STAGES-1];

  // State and phase counter register.
  always_ff @(posedge GL0 or posedge RESET) begin
    if (RESET) begin
      state_r <= WAIT_LOCK;
      cnt_r   <= '0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state logic; a sampled low always wins over soft reset and count completion.
  always_comb begin
    next_state_s = state_r;
    cnt_next_s   = cnt_r;
    loss_s       = 1'b0;
    case (state_r)
      WAIT_LOCK: begin
        if (lock_s) begin
          next_state_s = STABLE;
          cnt_next_s   = '0;
        end else begin
          next_state_s = WAIT_LOCK;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          next_state_s = WAIT_LOCK;
          cnt_next_s   = '0;
        end else if (cnt_r == STABLE_LAST) begin
          next_state_s = HOLD;
          cnt_next_s   = '0;
        end else begin
          cnt_next_s   = cnt_r + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!lock_s) begin
          next_state_s = WAIT_LOCK;
          cnt_next_s   = '0;
        end else if (EXT_RST_REQ) begin
          cnt_next_s   = '0;
        end else if (cnt_r == HOLD_LAST) begin
          next_state_s = RUN;
          cnt_next_s   = '0;
        end else begin
          cnt_next_s   = cnt_r + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          next_state_s = WAIT_LOCK;
          loss_s       = 1'b1;
        end else if (EXT_RST_REQ) begin
          next_state_s = HOLD;
          cnt_next_s   = '0;
        end else begin
          next_state_s = RUN;
        end
      end
      default: begin
        next_state_s = WAIT_LOCK;
        cnt_next_s   = '0;
      end
    endcase
  end

  // Output decode: ready follows the next state; clear is applied before the loss increment.
  always_comb begin
    run_next_s  = (next_state_s == RUN);
    loss_base_s = LOSS_CLR ? '0 : loss_cnt_r;
    if (loss_s) begin
      if (loss_base_s == LOSS_MAX) begin
        loss_cnt_next_s = loss_base_s;
      end else begin
        loss_cnt_next_s = loss_base_s + LOSS_CNT_W'(1);
      end
      lost_next_s = 1'b1;
    end else begin
      loss_cnt_next_s = loss_base_s;
      lost_next_s     = LOSS_CLR ? 1'b0 : lost_r;
    end
  end

  // Registered outputs so they switch on the same edge as the state.
  always_ff @(posedge GL0 or posedge RESET) begin
    if (RESET) begin
      fabric_reset_n_r <= 1'b0;
      clk_ready_r      <= 1'b0;
      loss_cnt_r       <= '0;
      lost_r           <= 1'b0;
    end else begin
      fabric_reset_n_r <= run_next_s;
      clk_ready_r      <= run_next_s;
      loss_cnt_r       <= loss_cnt_next_s;
      lost_r           <= lost_next_s;
    end
  end

  assign FABRIC_RESET_N = fabric_reset_n_r;
  assign CLK_READY      = clk_ready_r;
  assign LOCK_LOSS_CNT  = loss_cnt_r;
  assign LOCK_LOST      = lost_r;
  assign STATE          = state_r;

endmodule
